// File: rtl/serial_reduce_pkg.sv
// Shared types and constants for the serial frame reduction unit.
package serial_reduce_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam logic ACC_AND_INIT = 1'b1;
  localparam logic ACC_OR_INIT  = 1'b0;
  localparam logic ACC_XOR_INIT = 1'b0;

endpackage

// File: rtl/serial_reduce_if.sv
// Bit-in / frame-result-out handshake bundle for serial_reduce_unit.
interface serial_reduce_if #(
  parameter int unsigned FRAME_LEN = 8
);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_and;
  logic             out_or;
  logic             out_xor;
  logic             out_xnor;
  logic [CNT_W-1:0] out_ones;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_and, out_or, out_xor, out_xnor, out_ones
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_and, out_or, out_xor, out_xnor, out_ones
  );

endinterface

// File: rtl/serial_reduce_counter.sv
// Bit position counter within a frame; flags the final bit position.
module serial_reduce_counter #(
  parameter  int unsigned FRAME_LEN = 8,
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             last_c
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN - 1);

  // Clear has priority: it coincides with the accept of the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (accept) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last_c = (count == LAST_POS);

endmodule

// File: rtl/serial_reduce_unit.sv
// Accumulates AND/OR/XOR/ones over FRAME_LEN handshaked bits and presents
// the frame result on a valid/ready port.
module serial_reduce_unit
  import serial_reduce_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8
) (
  input logic            clk,
  input logic            rst,
  serial_reduce_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  state_e           state_q, state_d;
  logic             in_ready_c, out_valid_c;
  logic             accept_c, last_c, frame_done_c;
  logic [CNT_W-1:0] bit_cnt;

  logic             acc_and, acc_or, acc_xor;
  logic [CNT_W-1:0] acc_ones;
  logic             nxt_and, nxt_or, nxt_xor;
  logic [CNT_W-1:0] nxt_ones;

  logic             out_and_q, out_or_q, out_xor_q, out_xnor_q;
  logic [CNT_W-1:0] out_ones_q;

  // Accept is decoded from state so no input feeds back into in_ready.
  assign accept_c     = bus.in_valid && (state_q == ACCUM);
  assign frame_done_c = accept_c && last_c;

  serial_reduce_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .accept (accept_c),
    .clear  (frame_done_c),
    .count  (bit_cnt),
    .last_c (last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready_c = 1'b1;
        if (frame_done_c) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Running reductions including the bit presented this cycle.
  always_comb begin
    nxt_and  = acc_and & bus.in_bit;
    nxt_or   = acc_or | bus.in_bit;
    nxt_xor  = acc_xor ^ bus.in_bit;
    nxt_ones = acc_ones + CNT_W'(bus.in_bit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_and    <= ACC_AND_INIT;
      acc_or     <= ACC_OR_INIT;
      acc_xor    <= ACC_XOR_INIT;
      acc_ones   <= '0;
      out_and_q  <= 1'b0;
      out_or_q   <= 1'b0;
      out_xor_q  <= 1'b0;
      out_xnor_q <= 1'b1;
      out_ones_q <= '0;
    end else if (accept_c) begin
      if (frame_done_c) begin
        out_and_q  <= nxt_and;
        out_or_q   <= nxt_or;
        out_xor_q  <= nxt_xor;
        out_xnor_q <= ~nxt_xor;
        out_ones_q <= nxt_ones;
        acc_and    <= ACC_AND_INIT;
        acc_or     <= ACC_OR_INIT;
        acc_xor    <= ACC_XOR_INIT;
        acc_ones   <= '0;
      end else begin
        acc_and    <= nxt_and;
        acc_or     <= nxt_or;
        acc_xor    <= nxt_xor;
        acc_ones   <= nxt_ones;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_and   = out_and_q;
  assign bus.out_or    = out_or_q;
  assign bus.out_xor   = out_xor_q;
  assign bus.out_xnor  = out_xnor_q;
  assign bus.out_ones  = out_ones_q;

  a_cnt_range: assert property (@(posedge clk) disable iff (rst) bit_cnt < CNT_W'(FRAME_LEN));

endmodule

// File: tb/tb_serial_reduce_unit.sv
// Directed bench for serial_reduce_unit with FRAME_LEN=8 and FRAME_LEN=1 instances.
module tb_serial_reduce_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  serial_reduce_if #(.FRAME_LEN(8)) if8 ();
  serial_reduce_if #(.FRAME_LEN(1)) if1 ();

  serial_reduce_unit #(.FRAME_LEN(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  serial_reduce_unit #(.FRAME_LEN(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res8(input string tag, input int unsigned e_and, input int unsigned e_or,
                            input int unsigned e_xor, input int unsigned e_xnor, input int unsigned e_ones);
    check({tag, ".valid"}, 32'(if8.out_valid), 1);
    check({tag, ".ready"}, 32'(if8.in_ready), 0);
    check({tag, ".and"},   32'(if8.out_and), e_and);
    check({tag, ".or"},    32'(if8.out_or), e_or);
    check({tag, ".xor"},   32'(if8.out_xor), e_xor);
    check({tag, ".xnor"},  32'(if8.out_xnor), e_xnor);
    check({tag, ".ones"},  32'(if8.out_ones), e_ones);
  endtask

  task automatic check_res1(input string tag, input int unsigned e_and, input int unsigned e_or,
                            input int unsigned e_xor, input int unsigned e_xnor, input int unsigned e_ones);
    check({tag, ".valid"}, 32'(if1.out_valid), 1);
    check({tag, ".ready"}, 32'(if1.in_ready), 0);
    check({tag, ".and"},   32'(if1.out_and), e_and);
    check({tag, ".or"},    32'(if1.out_or), e_or);
    check({tag, ".xor"},   32'(if1.out_xor), e_xor);
    check({tag, ".xnor"},  32'(if1.out_xnor), e_xnor);
    check({tag, ".ones"},  32'(if1.out_ones), e_ones);
  endtask

  // Sends a frame MSB-first; gap inserts one idle cycle after every bit.
  task automatic send_frame8(input string tag, input logic [7:0] bits, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      check({tag, ".in_ready"}, 32'(if8.in_ready), 1);
      if8.in_valid = 1'b1;
      if8.in_bit   = bits[i];
      tick();
      if8.in_valid = 1'b0;
      if8.in_bit   = 1'b0;
      if (i != 0) begin
        check({tag, ".early_valid"}, 32'(if8.out_valid), 0);
        if (gap) tick();
      end
    end
  endtask

  task automatic deliver8(input string tag);
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(if8.out_valid), 0);
    check({tag, ".post_ready"}, 32'(if8.in_ready), 1);
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst          = 1'b1;
    if8.in_valid = 1'b0;
    if8.in_bit   = 1'b0;
    if8.out_ready = 1'b0;
    if1.in_valid = 1'b0;
    if1.in_bit   = 1'b0;
    if1.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst.in_ready",  32'(if8.in_ready), 1);
    check("rst.out_valid", 32'(if8.out_valid), 0);
    check("rst.and",       32'(if8.out_and), 0);
    check("rst.or",        32'(if8.out_or), 0);
    check("rst.xor",       32'(if8.out_xor), 0);
    check("rst.xnor",      32'(if8.out_xnor), 1);
    check("rst.ones",      32'(if8.out_ones), 0);
    check("rst1.xnor",     32'(if1.out_xnor), 1);
    check("rst1.in_ready", 32'(if1.in_ready), 1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // All ones
    send_frame8("t1", 8'b1111_1111, 1'b0);
    check_res8("t1", 1, 1, 0, 1, 8);
    deliver8("t1");

    // Mixed pattern with out_ready held high: one-cycle bubble
    if8.out_ready = 1'b1;
    send_frame8("t2", 8'b0100_1101, 1'b0);
    check_res8("t2", 0, 1, 0, 1, 4);
    tick();
    check("t2.bubble_valid", 32'(if8.out_valid), 0);
    check("t2.bubble_ready", 32'(if8.in_ready), 1);
    if8.out_ready = 1'b0;

    // All zeros under back-pressure; in_valid pushed with 1s must be ignored
    send_frame8("t3", 8'b0000_0000, 1'b0);
    check_res8("t3", 0, 0, 0, 1, 0);
    if8.in_valid = 1'b1;
    if8.in_bit   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_res8("t3.hold", 0, 0, 0, 1, 0);
    end
    if8.in_valid = 1'b0;
    if8.in_bit   = 1'b0;
    deliver8("t3");

    // Gapped input
    send_frame8("t4", 8'b1000_0000, 1'b1);
    check_res8("t4", 0, 1, 1, 0, 1);
    deliver8("t4");

    // Reset mid-frame discards partial accumulation
    for (int i = 0; i < 5; i++) begin
      if8.in_valid = 1'b1;
      if8.in_bit   = 1'b1;
      tick();
    end
    if8.in_valid = 1'b0;
    if8.in_bit   = 1'b0;
    rst = 1'b1;
    #2;
    check("t5.rst_ready", 32'(if8.in_ready), 1);
    check("t5.rst_valid", 32'(if8.out_valid), 0);
    check("t5.rst_ones",  32'(if8.out_ones), 0);
    tick();
    rst = 1'b0;
    tick();
    send_frame8("t5", 8'b0000_0001, 1'b0);
    check_res8("t5", 0, 1, 1, 0, 1);
    deliver8("t5");

    // FRAME_LEN=1: each accept completes a frame
    if1.out_ready = 1'b1;
    if1.in_valid  = 1'b1;
    if1.in_bit    = 1'b1;
    tick();
    check_res1("t6a", 1, 1, 1, 0, 1);
    if1.in_bit = 1'b0;
    tick();
    check("t6.bubble_valid", 32'(if1.out_valid), 0);
    check("t6.bubble_ready", 32'(if1.in_ready), 1);
    tick();
    if1.in_valid = 1'b0;
    check_res1("t6b", 0, 0, 0, 1, 0);
    tick();
    check("t6.end_valid", 32'(if1.out_valid), 0);
    check("t6.end_ready", 32'(if1.in_ready), 1);
    if1.out_ready = 1'b0;

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
